// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// sequencer states and the counter-width helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes are iterated for M cycles,
// then one FIX cycle restores signs and writes HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] hi,
  output logic [M-1:0] lo,
  output logic         dz
);

  localparam int CW = clog2(M);

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic            is_div_r, neg_lo, neg_hi, bz;
  logic [M-1:0]    opb;
  logic [2*M-1:0]  acc;

  logic            is_div, is_sgn;
  logic [M-1:0]    abs_a, abs_b;
  logic [M:0]      msum, shl;
  logic            ge;
  logic [M-1:0]    rem_nx;
  logic [2*M-1:0]  mul_nx, div_nx, prod;
  logic [M-1:0]    quo, rem, res_hi, res_lo;

  // Operand decode and inline magnitude; the most-negative value maps to
  // 2^(M-1), which is still exact when read as unsigned.
  always_comb begin
    is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    is_sgn = (op == MDU_MULT) || (op == MDU_DIV);
    abs_a  = (is_sgn && a[M-1]) ? -a : a;
    abs_b  = (is_sgn && b[M-1]) ? -b : b;
  end

  // One iteration step. Multiply keeps {partial product, multiplier} in acc;
  // divide keeps {remainder, dividend/quotient} in acc.
  always_comb begin
    msum   = {1'b0, acc[2*M-1:M]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nx = {msum, acc[M-1:1]};
    shl    = {acc[2*M-1:M], acc[M-1]};
    ge     = shl >= {1'b0, opb};
    rem_nx = ge ? M'(shl - {1'b0, opb}) : shl[M-1:0];
    div_nx = {rem_nx, acc[M-2:0], ge};
  end

  // Sign correction; a zero divisor forces an all-ones quotient while the
  // remainder path naturally reproduces the original dividend.
  always_comb begin
    prod   = neg_lo ? -acc : acc;
    quo    = neg_lo ? -acc[M-1:0] : acc[M-1:0];
    rem    = neg_hi ? -acc[2*M-1:M] : acc[2*M-1:M];
    res_hi = is_div_r ? rem : prod[2*M-1:M];
    res_lo = is_div_r ? (bz ? '1 : quo) : prod[M-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == CW'(M - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      is_div_r <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      bz       <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      dz       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count    <= '0;
          dz       <= 1'b0;
          is_div_r <= is_div;
          bz       <= (b == '0);
          neg_lo   <= is_sgn && (a[M-1] ^ b[M-1]);
          neg_hi   <= is_sgn && a[M-1];
          // Divide iterates the dividend; multiply iterates the multiplier.
          opb      <= is_div ? abs_b : abs_a;
          acc      <= {{M{1'b0}}, is_div ? abs_a : abs_b};
        end
        RUN: begin
          acc   <= is_div_r ? div_nx : mul_nx;
          count <= count + CW'(1);
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          dz   <= is_div_r && bz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
